// File: rtl/lsu_resp_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_resp_align
// Description : Tracks outstanding load/store request metadata in a small
//               FIFO and turns raw bus response beats into aligned,
//               sign/zero-extended load data. It also assembles two-beat
//               capability responses and accumulates bus errors per entry.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_resp_align #(
    parameter int unsigned Depth     = 2,
    parameter bit          CHERIoTEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cheri_pmode_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    input  logic        req_split_i,
    input  logic        req_is_cap_i,
    input  logic [3:0]  req_clrperm_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [32:0] data_rdata_i,
    output logic        resp_valid_o,
    output logic [32:0] resp_rdata_o,
    output logic [32:0] resp_cap_msw_o,
    output logic        resp_is_cap_o,
    output logic [3:0]  resp_clrperm_o,
    output logic        resp_we_o,
    output logic        resp_err_o,
    output logic        resp_spurious_o
);

    localparam int unsigned c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_CNT_W = $clog2(Depth + 1);

    // Metadata kept per outstanding request; cap already folds in pmode,
    // CHERIoTEn and ~we, and split is forced low for capability entries.
    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       sign_ext;
        logic [1:0] offset;
        logic       split;
        logic       cap;
        logic [3:0] clrperm;
    } entry_t;

    typedef enum logic [0:0] {
        IDLE_BEAT  = 1'b0,
        WAIT_BEAT2 = 1'b1
    } beat_e;

    entry_t               r_fifo [Depth];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    beat_e                r_beat;
    logic [31:8]          r_rdata_q;
    logic [32:0]          r_lsw_q;
    logic                 r_err_acc;

    entry_t               w_new_entry;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_eff_cap;
    logic                 w_beats2;
    logic                 w_beat_ok;
    logic                 w_first_beat;
    logic                 w_final;
    logic                 w_err;
    logic [15:0]          w_half;
    logic [7:0]           w_byte;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
        if (ptr == c_PTR_W'(Depth - 1)) begin
            return '0;
        end
        return ptr + c_PTR_W'(1);
    endfunction

    assign w_full      = (r_count == c_CNT_W'(Depth));
    assign w_empty     = (r_count == '0);
    assign req_ready_o = ~w_full;
    assign w_push      = req_valid_i & ~w_full;

    assign w_eff_cap = req_is_cap_i & cheri_pmode_i & CHERIoTEn & ~req_we_i;

    assign w_new_entry.we       = req_we_i;
    assign w_new_entry.typ      = req_type_i;
    assign w_new_entry.sign_ext = req_sign_ext_i;
    assign w_new_entry.offset   = req_offset_i;
    assign w_new_entry.split    = req_split_i & ~w_eff_cap;
    assign w_new_entry.cap      = w_eff_cap;
    assign w_new_entry.clrperm  = req_clrperm_i;

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_beats2 = w_head.cap | (w_head.split & ~w_head.we);

    // A beat is only matched against an entry that was already in the FIFO.
    assign w_beat_ok    = data_rvalid_i & ~w_empty;
    assign w_first_beat = w_beat_ok & (r_beat == IDLE_BEAT) & w_beats2;
    assign w_final      = w_beat_ok & ~w_first_beat;
    assign w_pop        = w_final;
    assign w_err        = r_err_acc | data_err_i;

    // Metadata storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_new_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat tracking: capture first-beat data and errors, release on the final beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_beat    <= IDLE_BEAT;
            r_rdata_q <= '0;
            r_lsw_q   <= '0;
            r_err_acc <= 1'b0;
        end else if (w_first_beat) begin
            r_beat    <= WAIT_BEAT2;
            r_err_acc <= data_err_i;
            if (w_head.split) begin
                r_rdata_q <= data_rdata_i[31:8];
            end
            if (w_head.cap) begin
                r_lsw_q <= data_rdata_i;
            end
        end else if (w_final) begin
            r_beat    <= IDLE_BEAT;
            r_err_acc <= 1'b0;
        end
    end

    // Half/byte lane selection, stitching in first-beat bytes for split halves.
    always_comb begin
        w_half = 16'h0000;
        w_byte = 8'h00;
        case (w_head.offset)
            2'd0: begin
                w_half = data_rdata_i[15:0];
                w_byte = data_rdata_i[7:0];
            end
            2'd1: begin
                w_half = data_rdata_i[23:8];
                w_byte = data_rdata_i[15:8];
            end
            2'd2: begin
                w_half = data_rdata_i[31:16];
                w_byte = data_rdata_i[23:16];
            end
            default: begin
                w_half = {data_rdata_i[7:0], r_rdata_q[31:24]};
                w_byte = data_rdata_i[31:24];
            end
        endcase
    end

    // Response formatting; every data output is zero unless a response completes.
    always_comb begin
        resp_valid_o    = w_final;
        resp_spurious_o = data_rvalid_i & w_empty;
        resp_rdata_o    = '0;
        resp_cap_msw_o  = '0;
        resp_is_cap_o   = 1'b0;
        resp_clrperm_o  = 4'h0;
        resp_we_o       = 1'b0;
        resp_err_o      = 1'b0;
        if (w_final) begin
            resp_err_o     = w_err;
            resp_clrperm_o = w_head.clrperm;
            resp_we_o      = w_head.we;
            if (w_head.we) begin
                resp_rdata_o = '0;
            end else if (w_head.cap) begin
                resp_rdata_o   = r_lsw_q;
                resp_is_cap_o  = 1'b1;
                resp_cap_msw_o = w_err ? 33'd0 : data_rdata_i;
            end else if (w_head.typ == 2'b00) begin
                case (w_head.offset)
                    2'd0:    resp_rdata_o = data_rdata_i;
                    2'd1:    resp_rdata_o = {1'b0, data_rdata_i[7:0],  r_rdata_q[31:8]};
                    2'd2:    resp_rdata_o = {1'b0, data_rdata_i[15:0], r_rdata_q[31:16]};
                    default: resp_rdata_o = {1'b0, data_rdata_i[23:0], r_rdata_q[31:24]};
                endcase
            end else if (w_head.typ == 2'b01) begin
                resp_rdata_o = {1'b0, {16{w_head.sign_ext & w_half[15]}}, w_half};
            end else begin
                resp_rdata_o = {1'b0, {24{w_head.sign_ext & w_byte[7]}}, w_byte};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_resp_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_resp_align
// Description : Directed self-checking bench for lsu_resp_align.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_resp_align;

    logic        clk;
    logic        rst_n;
    logic        cheri_pmode;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_type;
    logic        req_sign_ext;
    logic [1:0]  req_offset;
    logic        req_split;
    logic        req_is_cap;
    logic [3:0]  req_clrperm;
    logic        data_rvalid;
    logic        data_err;
    logic [32:0] data_rdata;
    logic        resp_valid;
    logic [32:0] resp_rdata;
    logic [32:0] resp_cap_msw;
    logic        resp_is_cap;
    logic [3:0]  resp_clrperm;
    logic        resp_we;
    logic        resp_err;
    logic        resp_spurious;

    int n_pass = 0;
    int n_total = 0;

    lsu_resp_align #(
        .Depth     (2),
        .CHERIoTEn (1'b1)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cheri_pmode_i   (cheri_pmode),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_type_i      (req_type),
        .req_sign_ext_i  (req_sign_ext),
        .req_offset_i    (req_offset),
        .req_split_i     (req_split),
        .req_is_cap_i    (req_is_cap),
        .req_clrperm_i   (req_clrperm),
        .data_rvalid_i   (data_rvalid),
        .data_err_i      (data_err),
        .data_rdata_i    (data_rdata),
        .resp_valid_o    (resp_valid),
        .resp_rdata_o    (resp_rdata),
        .resp_cap_msw_o  (resp_cap_msw),
        .resp_is_cap_o   (resp_is_cap),
        .resp_clrperm_o  (resp_clrperm),
        .resp_we_o       (resp_we),
        .resp_err_o      (resp_err),
        .resp_spurious_o (resp_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clr_inputs();
        cheri_pmode  = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_type     = 2'b00;
        req_sign_ext = 1'b0;
        req_offset   = 2'b00;
        req_split    = 1'b0;
        req_is_cap   = 1'b0;
        req_clrperm  = 4'h0;
        data_rvalid  = 1'b0;
        data_err     = 1'b0;
        data_rdata   = 33'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clr_inputs();
    endtask

    task automatic set_req(input logic we, input logic [1:0] typ, input logic sx,
                           input logic [1:0] off, input logic split, input logic cap,
                           input logic [3:0] perm);
        req_valid    = 1'b1;
        req_we       = we;
        req_type     = typ;
        req_sign_ext = sx;
        req_offset   = off;
        req_split    = split;
        req_is_cap   = cap;
        req_clrperm  = perm;
    endtask

    task automatic beat(input logic [32:0] d, input logic err);
        data_rvalid = 1'b1;
        data_rdata  = d;
        data_err    = err;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready",    33'(req_ready),     33'd1);
        chk("reset_valid",    33'(resp_valid),    33'd0);
        chk("reset_spurious", 33'(resp_spurious), 33'd0);

        // Aligned word load
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk("word_push_ready", 33'(req_ready), 33'd1);
        next_cycle(); beat(33'h1_DEADBEEF, 1'b0);
        @(negedge clk);
        chk("word_valid", 33'(resp_valid), 33'd1);
        chk("word_rdata", resp_rdata, 33'h1_DEADBEEF);
        chk("word_msw",   resp_cap_msw, 33'd0);
        chk("word_err",   33'(resp_err), 33'd0);
        next_cycle();
        @(negedge clk);
        chk("idle_valid", 33'(resp_valid), 33'd0);
        chk("idle_rdata", resp_rdata, 33'd0);

        // Split signed half at offset 3
        next_cycle(); set_req(1'b0, 2'b01, 1'b1, 2'd3, 1'b1, 1'b0, 4'h0);
        next_cycle(); beat(33'h0_AB000000, 1'b0);
        @(negedge clk);
        chk("half_split_b1_valid", 33'(resp_valid), 33'd0);
        next_cycle(); beat(33'h0_000000CD, 1'b0);
        @(negedge clk);
        chk("half_split_valid", 33'(resp_valid), 33'd1);
        chk("half_split_rdata", resp_rdata, 33'h0_FFFFCDAB);

        // Split word at offset 1
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0, 4'h0);
        next_cycle(); beat(33'h0_44332211, 1'b0);
        @(negedge clk);
        chk("word_split_b1_valid", 33'(resp_valid), 33'd0);
        next_cycle(); beat(33'h0_88776655, 1'b0);
        @(negedge clk);
        chk("word_split_rdata", resp_rdata, 33'h0_55443322);

        // Capability load with error on first beat
        next_cycle(); cheri_pmode = 1'b1; set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 4'h3);
        next_cycle(); beat(33'h1_11111111, 1'b1);
        @(negedge clk);
        chk("cap_err_b1_valid", 33'(resp_valid), 33'd0);
        next_cycle(); beat(33'h1_22222222, 1'b0);
        @(negedge clk);
        chk("cap_err_valid",   33'(resp_valid), 33'd1);
        chk("cap_err_is_cap",  33'(resp_is_cap), 33'd1);
        chk("cap_err_err",     33'(resp_err), 33'd1);
        chk("cap_err_rdata",   resp_rdata, 33'h1_11111111);
        chk("cap_err_msw",     resp_cap_msw, 33'd0);
        chk("cap_err_clrperm", 33'(resp_clrperm), 33'h3);

        // Clean capability load
        next_cycle(); cheri_pmode = 1'b1; set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 4'hA);
        next_cycle(); beat(33'h0_12345678, 1'b0);
        next_cycle(); beat(33'h1_87654321, 1'b0);
        @(negedge clk);
        chk("cap_rdata",   resp_rdata, 33'h0_12345678);
        chk("cap_msw",     resp_cap_msw, 33'h1_87654321);
        chk("cap_err",     33'(resp_err), 33'd0);
        chk("cap_clrperm", 33'(resp_clrperm), 33'hA);

        // Cap request outside pure-cap mode is a plain single-beat word
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0);
        next_cycle(); beat(33'h1_CAFEF00D, 1'b0);
        @(negedge clk);
        chk("nocap_valid",  33'(resp_valid), 33'd1);
        chk("nocap_is_cap", 33'(resp_is_cap), 33'd0);
        chk("nocap_rdata",  resp_rdata, 33'h1_CAFEF00D);

        // Store response with bus error
        next_cycle(); set_req(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
        next_cycle(); beat(33'h1_FFFFFFFF, 1'b1);
        @(negedge clk);
        chk("store_valid", 33'(resp_valid), 33'd1);
        chk("store_rdata", resp_rdata, 33'd0);
        chk("store_we",    33'(resp_we), 33'd1);
        chk("store_err",   33'(resp_err), 33'd1);

        // Byte and half lane selection
        next_cycle(); set_req(1'b0, 2'b10, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0);
        next_cycle(); beat(33'h0_00800000, 1'b0);
        @(negedge clk);
        chk("byte_sx_rdata", resp_rdata, 33'h0_FFFFFF80);
        next_cycle(); set_req(1'b0, 2'b11, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0);
        next_cycle(); beat(33'h1_0000A500, 1'b0);
        @(negedge clk);
        chk("byte_zx_rdata", resp_rdata, 33'h0_000000A5);
        next_cycle(); set_req(1'b0, 2'b01, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0);
        next_cycle(); beat(33'h0_00BEEF00, 1'b0);
        @(negedge clk);
        chk("half_zx_rdata", resp_rdata, 33'h0_0000BEEF);

        // Back-to-back pushes against a full FIFO
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk("full_p1_ready", 33'(req_ready), 33'd1);
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk("full_p2_ready", 33'(req_ready), 33'd1);
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        chk("full_p3_stall", 33'(req_ready), 33'd0);
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0); beat(33'h0_00000001, 1'b0);
        @(negedge clk);
        chk("full_pop_no_bypass", 33'(req_ready), 33'd0);
        chk("full_r1_valid",      33'(resp_valid), 33'd1);
        chk("full_r1_rdata",      resp_rdata, 33'h0_00000001);
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0); beat(33'h0_00000002, 1'b0);
        @(negedge clk);
        chk("full_p3_ready", 33'(req_ready), 33'd1);
        chk("full_r2_rdata", resp_rdata, 33'h0_00000002);
        next_cycle(); beat(33'h0_00000003, 1'b0);
        @(negedge clk);
        chk("full_r3_valid", 33'(resp_valid), 33'd1);
        chk("full_r3_rdata", resp_rdata, 33'h0_00000003);
        next_cycle(); beat(33'h0_00000004, 1'b0);
        @(negedge clk);
        chk("spur_flag",  33'(resp_spurious), 33'd1);
        chk("spur_valid", 33'(resp_valid), 33'd0);
        chk("spur_rdata", resp_rdata, 33'd0);
        next_cycle();
        @(negedge clk);
        chk("spur_one_cycle", 33'(resp_spurious), 33'd0);

        // Response in the push cycle is not matched to the new entry
        next_cycle(); set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0); beat(33'h0_00000077, 1'b0);
        @(negedge clk);
        chk("nobypass_spurious", 33'(resp_spurious), 33'd1);
        chk("nobypass_valid",    33'(resp_valid), 33'd0);
        next_cycle(); beat(33'h0_00000088, 1'b0);
        @(negedge clk);
        chk("nobypass_next_valid", 33'(resp_valid), 33'd1);
        chk("nobypass_next_rdata", resp_rdata, 33'h0_00000088);

        // Reset while waiting for the second capability beat
        next_cycle(); cheri_pmode = 1'b1; set_req(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 4'h0);
        next_cycle(); beat(33'h1_55555555, 1'b0);
        @(negedge clk);
        chk("rst_mid_b1_valid", 33'(resp_valid), 33'd0);
        next_cycle(); rst_n = 1'b0;
        next_cycle(); rst_n = 1'b1; beat(33'h1_66666666, 1'b0);
        @(negedge clk);
        chk("rst_mid_spurious", 33'(resp_spurious), 33'd1);
        chk("rst_mid_valid",    33'(resp_valid), 33'd0);
        chk("rst_mid_ready",    33'(req_ready), 33'd1);

        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
